// File: rtl/fb_scan_reader.sv
// Raster-scan read engine: streams an H_PIXELS x V_LINES frame from a 1-cycle-latency RAM
// through a small output FIFO. Define SCAN_CONTINUOUS_EN for free-running frame repeat.
module fb_scan_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int H_PIXELS   = 16,
   parameter int V_LINES    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_sof,
   output logic                  pix_eol,
   output logic                  pix_eof,
   output logic                  busy,
   output logic                  done
);
   localparam int XW = $clog2(H_PIXELS);
   localparam int YW = $clog2(V_LINES + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   typedef struct packed {logic sof; logic eol; logic eof;} tag_t;
   typedef struct packed {logic [DATA_WIDTH-1:0] data; tag_t tag;} entry_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] offset;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   // issue_vld: ram_addr is a real read this cycle; ret_vld: its data is on ram_q this cycle
   logic                  issue_vld;
   logic                  ret_vld;
   tag_t                  issue_tag;
   tag_t                  ret_tag;
   entry_t                fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;

   entry_t head;
   logic   pop;
   logic   push;
   logic   credit_ok;
   logic   last_px;

   assign head      = fifo_mem[rd_ptr];
   assign pix_valid = (count != '0);
   assign pop       = pix_valid & pix_ready;
   assign push      = ret_vld;
   // Reads still in the pipe count against FIFO space so a push can never overflow
   assign credit_ok = (count + CW'(issue_vld) + CW'(ret_vld)) < CW'(FIFO_DEPTH);
   assign last_px   = (x == X_LAST) && (y == Y_LAST);

   assign pix_data = pix_valid ? head.data    : '0;
   assign pix_sof  = pix_valid & head.tag.sof;
   assign pix_eol  = pix_valid & head.tag.eol;
   assign pix_eof  = pix_valid & head.tag.eof;

   // NOTE: FIFO storage has no reset; every output is gated by pix_valid so stale words never show.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= {ram_q, ret_tag};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base      <= '0;
         offset    <= '0;
         x         <= '0;
         y         <= '0;
         ram_addr  <= '0;
         issue_vld <= 1'b0;
         ret_vld   <= 1'b0;
         issue_tag <= '0;
         ret_tag   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ret_vld   <= issue_vld;
         ret_tag   <= issue_tag;
         issue_vld <= 1'b0;
         done      <= pop & head.tag.eof;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);

         case (state)
            IDLE: begin
               // Pixel 0 is issued on the accepting edge to reach first data in 3 cycles
               if (start) begin
                  base      <= base_addr;
                  ram_addr  <= base_addr;
                  issue_vld <= 1'b1;
                  issue_tag <= {1'b1, 1'b0, 1'b0};
                  x         <= XW'(1);
                  y         <= '0;
                  offset    <= ADDR_WIDTH'(1);
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (credit_ok) begin
                  ram_addr  <= base + offset;
                  issue_vld <= 1'b1;
                  issue_tag <= {(x == '0) && (y == '0), x == X_LAST, last_px};
                  if (last_px) begin
`ifdef SCAN_CONTINUOUS_EN
                     x      <= '0;
                     y      <= '0;
                     offset <= '0;
`else
                     state  <= DRAIN;
`endif
                  end else begin
                     offset <= offset + ADDR_WIDTH'(1);
                     if (x == X_LAST) begin
                        x <= '0;
                        y <= y + YW'(1);
                     end else begin
                        x <= x + XW'(1);
                     end
                  end
               end
            end
            DRAIN: begin
               if (pop && head.tag.eof) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_scan_reader.sv
// Self-checking bench for fb_scan_reader: frame table, random ready/data, reset and
// (with SCAN_CONTINUOUS_EN) back-to-back frame sequences against a reference model.
module tb_fb_scan_reader;
   localparam int DW = 8, AW = 8, H = 4, V = 2, DEPTH = 4, NPIX = H * V;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_q = '0;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic          pix_sof, pix_eol, pix_eof, busy, done;

   int tests = 0;
   int failed = 0;

   logic [DW-1:0] mem [256];

   typedef struct {
      logic [AW-1:0] base;
      int            mode;      // 0 ready=1, 1 toggle, 2 hold-off 20 cycles, 3 random
      bit            rnd_fill;
      logic [AW-1:0] exp_first;
      logic [AW-1:0] exp_last;
   } frame_t;

   fb_scan_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .ram_addr(ram_addr), .ram_q(ram_q), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Registered-read RAM model
   always @(posedge clock) ram_q <= mem[ram_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fill(input bit rnd);
      for (int i = 0; i < 256; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   function automatic logic [10:0] model_pix(input logic [AW-1:0] base, input int idx);
      int k;
      k = idx % NPIX;
      return {mem[8'(base + k)], k == 0, (k % H) == H - 1, k == NPIX - 1};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_addr"},  ram_addr, 0);
      check({tag, "_valid"}, pix_valid, 0);
      check({tag, "_data"},  {pix_data, pix_sof, pix_eol, pix_eof}, 0);
      check({tag, "_busy"},  {busy, done}, 0);
   endtask

   task automatic run_frame(input frame_t r);
      logic [AW-1:0] addr_q[$];
      logic [10:0]   prev_out = '0;
      logic          prev_stall = 1'b0;
      int cyc = 1, accepted = 0, dones = 0, done_cyc = -1, first_cyc = -1, last_cyc = -1;
      int max_ahead = 0, stable_errs = 0;
      bit addr_ok;

      fill(r.rnd_fill);
      @(negedge clock);
      base_addr = r.base;
      start     = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      while (cyc < 300 && dones == 0) begin
         case (r.mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = (cyc % 2) == 1;
            2:       pix_ready = cyc > 20;
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
         if (cyc == 1) check("busy_after_start", busy, 1);
         if (cyc == 1 || ram_addr != addr_q[addr_q.size() - 1]) addr_q.push_back(ram_addr);
         if (addr_q.size() - accepted > max_ahead) max_ahead = addr_q.size() - accepted;
         if (prev_stall && (!pix_valid || {pix_data, pix_sof, pix_eol, pix_eof} != prev_out))
            stable_errs++;
         if (r.mode == 2 && cyc == 20) begin
            check("holdoff_reads", addr_q.size(), DEPTH);
            check("holdoff_valid", pix_valid, 1);
         end
         if (pix_valid && pix_ready) begin
            check($sformatf("pix%0d", accepted), {pix_data, pix_sof, pix_eol, pix_eof},
                  model_pix(r.base, accepted));
            if (accepted == 0) first_cyc = cyc;
            last_cyc = cyc;
            accepted++;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            check("busy_at_done", busy, 0);
         end
         prev_stall = pix_valid && !pix_ready;
         prev_out   = {pix_data, pix_sof, pix_eol, pix_eof};
         @(negedge clock);
         cyc++;
      end
      check("done_seen", dones, 1);
      check("done_pulse", done, 0);
      check("pix_count", accepted, NPIX);
      check("stall_stable_errs", stable_errs, 0);
      check("credit_ahead_ok", max_ahead <= DEPTH, 1);
      addr_ok = (addr_q.size() == NPIX);
      for (int i = 0; i < addr_q.size() && i < NPIX; i++)
         if (addr_q[i] != 8'(r.base + i)) addr_ok = 1'b0;
      check("addr_sequence", addr_ok, 1);
      check("addr_first", addr_q[0], r.exp_first);
      check("addr_last", ram_addr, r.exp_last);
      if (r.mode == 0) begin
         check("first_pix_cycle", first_cyc, 3);
         check("last_pix_cycle", last_cyc, 3 + NPIX - 1);
         check("done_cycle", done_cyc, 3 + NPIX);
      end
   endtask

   task automatic mid_frame_reset();
      int cyc = 1, accepted = 0, late_valid = 0;
      fill(1'b0);
      @(negedge clock);
      base_addr = 8'h00;
      start     = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      pix_ready = 1'b1;
      while (accepted < 3 && cyc < 40) begin
         if (cyc == 2) begin
            start     = 1'b1;
            base_addr = 8'h80;
         end else begin
            start     = 1'b0;
            base_addr = 8'h00;
         end
         if (pix_valid) begin
            check($sformatf("mid_pix%0d", accepted), {pix_data, pix_sof}, {8'(accepted), accepted == 0});
            accepted++;
         end
         @(negedge clock);
         cyc++;
      end
      check("mid_accepted", accepted, 3);
      check("mid_busy", busy, 1);
      check("mid_base_kept", ram_addr[7], 0);
      pix_ready = 1'b0;
      reset     = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      @(negedge clock);
      reset     = 1'b0;
      pix_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (pix_valid || busy) late_valid++;
      end
      check("post_reset_quiet", late_valid, 0);
   endtask

`ifdef SCAN_CONTINUOUS_EN
   task automatic continuous_frames();
      int cyc = 1, accepted = 0, dones = 0, gaps = 0, busy_drops = 0;
      fill(1'b0);
      @(negedge clock);
      base_addr = 8'h00;
      start     = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      pix_ready = 1'b1;
      while (cyc <= 3 + 2 * NPIX && cyc < 100) begin
         if (!busy) busy_drops++;
         if (done) dones++;
         if (pix_valid && accepted < 2 * NPIX) begin
            check($sformatf("cont_pix%0d", accepted), {pix_data, pix_sof, pix_eol, pix_eof},
                  model_pix(8'h00, accepted));
            if (cyc != 3 + accepted) gaps++;
            accepted++;
         end
         @(negedge clock);
         cyc++;
      end
      check("cont_count", accepted, 2 * NPIX);
      check("cont_no_bubble", gaps, 0);
      check("cont_dones", dones, 2);
      check("cont_busy_held", busy_drops, 0);
      reset = 1'b1;
      #1;
      check_idle_outputs("cont_reset");
      @(negedge clock);
      reset = 1'b0;
   endtask
`endif

   initial begin
      frame_t tbl[6];
      tbl[0] = '{base: 8'h00, mode: 0, rnd_fill: 1'b0, exp_first: 8'h00, exp_last: 8'h07};
      tbl[1] = '{base: 8'h00, mode: 1, rnd_fill: 1'b0, exp_first: 8'h00, exp_last: 8'h07};
      tbl[2] = '{base: 8'hFC, mode: 0, rnd_fill: 1'b0, exp_first: 8'hFC, exp_last: 8'h03};
      tbl[3] = '{base: 8'h00, mode: 2, rnd_fill: 1'b0, exp_first: 8'h00, exp_last: 8'h07};
      for (int i = 4; i < 6; i++) begin
         tbl[i].base      = 8'($urandom);
         tbl[i].mode      = 3;
         tbl[i].rnd_fill  = 1'b1;
         tbl[i].exp_first = tbl[i].base;
         tbl[i].exp_last  = 8'(tbl[i].base + NPIX - 1);
      end
      fill(1'b0);

      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clock);
      check_idle_outputs("post_reset");

`ifdef SCAN_CONTINUOUS_EN
      continuous_frames();
`else
      for (int i = 0; i < 6; i++) run_frame(tbl[i]);
      mid_frame_reset();
      run_frame(tbl[0]);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
